// File: rtl/neuron_param_loader.sv
// Configuration sequencer for one neuron grid core: reassembles a 32-bit word stream
// into parameter entries and packed 2-bit instructions and drives the grid write ports.
module neuron_param_loader #(
    parameter int NUM_NEURONS = 256,
    parameter int PARAM_WIDTH = 368
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           grid_idle,
    input  logic                           cfg_valid,
    input  logic [31:0]                    cfg_data,
    output logic                           cfg_ready,
    output logic                           param_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] param_address,
    output logic [PARAM_WIDTH-1:0]         param_data_in,
    output logic                           neuron_inst_wen,
    output logic [$clog2(NUM_NEURONS)-1:0] neuron_inst_address,
    output logic [1:0]                     neuron_inst_data_in,
    output logic                           busy,
    output logic                           tick_hold,
    output logic                           done
);
    localparam int AW  = $clog2(NUM_NEURONS);
    localparam int WPE = (PARAM_WIDTH + 31) / 32;
    localparam int WW  = (WPE > 1) ? $clog2(WPE) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_P_COLLECT = 3'd1,
        S_P_WRITE   = 3'd2,
        S_I_COLLECT = 3'd3,
        S_I_WRITE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          ncnt_q, ncnt_d;
    logic [WW-1:0]          wcnt_q, wcnt_d;
    logic [PARAM_WIDTH-1:0] asm_q, asm_d;
    logic [AW-1:0]          paddr_q, paddr_d;
    logic [31:0]            isr_q, isr_d;
    logic                   cfg_ready_s;
    logic                   hs_s;

    // Abort withdraws ready so a word offered in the abort cycle is never consumed.
    assign cfg_ready_s = ((state_q == S_P_COLLECT) || (state_q == S_I_COLLECT)) && !abort;
    assign hs_s        = cfg_valid && cfg_ready_s;

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        state_d = state_q;
        ncnt_d  = ncnt_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        paddr_d = paddr_q;
        isr_d   = isr_q;
        if (abort) begin
            state_d = S_IDLE;
            ncnt_d  = {AW{1'b0}};
            wcnt_d  = {WW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && grid_idle) begin
                        state_d = S_P_COLLECT;
                        ncnt_d  = {AW{1'b0}};
                        wcnt_d  = {WW{1'b0}};
                        asm_d   = {PARAM_WIDTH{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_P_COLLECT: begin
                    if (hs_s) begin
                        // Bits of the final word beyond PARAM_WIDTH have no home and fall away.
                        for (int b = 0; b < PARAM_WIDTH; b++) begin
                            if ((b / 32) == int'(wcnt_q)) begin
                                asm_d[b] = cfg_data[b % 32];
                            end else begin
                                asm_d[b] = asm_q[b];
                            end
                        end
                        if (wcnt_q == WW'(WPE - 1)) begin
                            state_d = S_P_WRITE;
                            paddr_d = ncnt_q;
                        end else begin
                            wcnt_d = wcnt_q + WW'(1);
                        end
                    end else begin
                        state_d = S_P_COLLECT;
                    end
                end
                S_P_WRITE: begin
                    wcnt_d = {WW{1'b0}};
                    if (ncnt_q == AW'(NUM_NEURONS - 1)) begin
                        ncnt_d  = {AW{1'b0}};
                        state_d = S_I_COLLECT;
                    end else begin
                        ncnt_d  = ncnt_q + AW'(1);
                        state_d = S_P_COLLECT;
                    end
                end
                S_I_COLLECT: begin
                    if (hs_s) begin
                        isr_d   = cfg_data;
                        state_d = S_I_WRITE;
                    end else begin
                        state_d = S_I_COLLECT;
                    end
                end
                S_I_WRITE: begin
                    isr_d  = {2'b00, isr_q[31:2]};
                    ncnt_d = ncnt_q + AW'(1);
                    // Groups start 16-aligned, so the low nibble marks the 16th write.
                    if (ncnt_q[3:0] == 4'hF) begin
                        if (ncnt_q == AW'(NUM_NEURONS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_I_COLLECT;
                        end
                    end else begin
                        state_d = S_I_WRITE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    ncnt_d  = {AW{1'b0}};
                    wcnt_d  = {WW{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ncnt_q  <= {AW{1'b0}};
            wcnt_q  <= {WW{1'b0}};
            asm_q   <= {PARAM_WIDTH{1'b0}};
            paddr_q <= {AW{1'b0}};
            isr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ncnt_q  <= ncnt_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            paddr_q <= paddr_d;
            isr_q   <= isr_d;
        end
    end

    assign cfg_ready           = cfg_ready_s;
    assign param_wen           = (state_q == S_P_WRITE) && !abort;
    assign param_address       = paddr_q;
    assign param_data_in       = asm_q;
    assign neuron_inst_wen     = (state_q == S_I_WRITE) && !abort;
    assign neuron_inst_address = ncnt_q;
    assign neuron_inst_data_in = isr_q[1:0];
    assign busy                = (state_q != S_IDLE);
    assign tick_hold           = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE) && !abort;

endmodule
